// File: rtl/fp_round_pack.sv
// Round-half-up and pack stage for the 8-bit {S,E,F} float: one output register
// plus a one-entry skid buffer, with saturating round/saturate statistics.
module fp_round_pack #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [2:0]       E,
    input  logic [3:0]       M,
    input  logic             T,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_S,
    output logic [2:0]       out_E,
    output logic [3:0]       out_F,
    output logic [CNT_W-1:0] round_cnt,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // in_ready is registered and low only while the skid register holds a sample.
    logic       in_fire;
    logic       out_fire;
    logic       or_free;
    logic       or_full;
    logic       sk_full;
    logic       or_full_n;
    logic       sk_full_n;
    logic [7:0] or_word;
    logic [7:0] sk_word;
    logic [7:0] rnd_word;
    logic [2:0] rnd_e;
    logic [3:0] rnd_f;
    logic       rnd_sat;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = or_full & out_ready;
    assign or_free  = !or_full || out_fire;

    always_comb begin
        rnd_e   = E;
        rnd_f   = M;
        rnd_sat = 1'b0;
        if (T) begin
            if (M != 4'hF) begin
                rnd_f = M + 4'd1;
            end else if (E != 3'd7) begin
                // Significand carry-out renormalises to 1.000 with a bumped exponent.
                rnd_f = 4'b1000;
                rnd_e = E + 3'd1;
            end else begin
                rnd_f   = 4'b1111;
                rnd_e   = 3'd7;
                rnd_sat = 1'b1;
            end
        end
    end

    assign rnd_word = {S, rnd_e, rnd_f};

    always_comb begin
        or_full_n = or_full;
        sk_full_n = sk_full;
        if (or_free) begin
            if (sk_full) begin
                or_full_n = 1'b1;
                sk_full_n = 1'b0;
            end else begin
                or_full_n = in_fire;
            end
        end else if (in_fire) begin
            sk_full_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            or_full  <= 1'b0;
            sk_full  <= 1'b0;
            or_word  <= 8'd0;
            sk_word  <= 8'd0;
            in_ready <= 1'b1;
        end else begin
            or_full  <= or_full_n;
            sk_full  <= sk_full_n;
            in_ready <= !sk_full_n;
            if (or_free) begin
                if (sk_full) begin
                    or_word <= sk_word;
                end else if (in_fire) begin
                    or_word <= rnd_word;
                end
            end else if (in_fire) begin
                sk_word <= rnd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_cnt <= '0;
            sat_cnt   <= '0;
        end else if (clr) begin
            round_cnt <= '0;
            sat_cnt   <= '0;
        end else if (in_fire) begin
            if (T && round_cnt != CNT_MAX) begin
                round_cnt <= round_cnt + 1'b1;
            end
            if (rnd_sat && sat_cnt != CNT_MAX) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    assign out_valid = or_full;
    assign out_S     = or_word[7];
    assign out_E     = or_word[6:4];
    assign out_F     = or_word[3:0];

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed vector table, backpressure/reset sequences and
// randomized traffic checked by a scoreboard against an arithmetic rounding model.
module tb_fp_round_pack;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic       S;
    logic [2:0] E;
    logic [3:0] M;
    logic       T;
    logic       out_valid;
    logic       out_ready;
    logic       out_S;
    logic [2:0] out_E;
    logic [3:0] out_F;
    logic [7:0] round_cnt;
    logic [7:0] sat_cnt;

    logic       in_ready2;
    logic       out_valid2;
    logic       out_S2;
    logic [2:0] out_E2;
    logic [3:0] out_F2;
    logic [1:0] round_cnt2;
    logic [1:0] sat_cnt2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    int         model_rc = 0;
    int         model_sc = 0;
    logic       hold_valid = 1'b0;
    logic [7:0] hold_val = 8'd0;

    fp_round_pack #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .M(M), .T(T), .out_valid(out_valid), .out_ready(out_ready),
        .out_S(out_S), .out_E(out_E), .out_F(out_F),
        .round_cnt(round_cnt), .sat_cnt(sat_cnt)
    );

    fp_round_pack #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .S(S), .E(E), .M(M), .T(T), .out_valid(out_valid2), .out_ready(out_ready),
        .out_S(out_S2), .out_E(out_E2), .out_F(out_F2),
        .round_cnt(round_cnt2), .sat_cnt(sat_cnt2)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: add the round bit as an integer, then resolve a carry past 15.
    function automatic logic [7:0] ref_round(logic s, logic [2:0] e, logic [3:0] m,
                                             logic t, output logic sat);
        int sig;
        int ex;
        sig = int'(m) + int'(t);
        ex  = int'(e);
        sat = 1'b0;
        if (sig == 16) begin
            if (ex < 7) begin
                ex  = ex + 1;
                sig = 8;
            end else begin
                sig = 15;
                sat = 1'b1;
            end
        end
        return {s, ex[2:0], sig[3:0]};
    endfunction

    function automatic int sat_to(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Scoreboard/monitor, sampled mid-cycle when inputs and outputs are both settled.
    always @(negedge clk) begin
        logic [7:0] cur;
        logic [7:0] w;
        logic       sat;
        cur = {out_S, out_E, out_F};
        if (rst) begin
            exp_q.delete();
            model_rc   = 0;
            model_sc   = 0;
            hold_valid = 1'b0;
        end else begin
            check("round_cnt8", int'(round_cnt), sat_to(model_rc, 255));
            check("sat_cnt8", int'(sat_cnt), sat_to(model_sc, 255));
            check("round_cnt2", int'(round_cnt2), sat_to(model_rc, 3));
            check("sat_cnt2", int'(sat_cnt2), sat_to(model_sc, 3));
            if (hold_valid) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(cur), int'(hold_val));
            end
            hold_valid = out_valid && !out_ready;
            hold_val   = cur;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", int'(cur), -1);
                end else begin
                    w = exp_q.pop_front();
                    check("sb_data", int'(cur), int'(w));
                end
            end
            if (clr) begin
                model_rc = 0;
                model_sc = 0;
            end
            if (in_valid && in_ready) begin
                w = ref_round(S, E, M, T, sat);
                exp_q.push_back(w);
                if (!clr) begin
                    model_rc = model_rc + int'(T);
                    model_sc = model_sc + int'(sat);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(logic v, logic s, logic [2:0] e, logic [3:0] m, logic t);
        in_valid = v;
        S = s;
        E = e;
        M = m;
        T = t;
    endtask

    typedef struct {
        logic       s;
        logic [2:0] e;
        logic [3:0] m;
        logic       t;
        logic [2:0] exp_e;
        logic [3:0] exp_f;
        int         exp_rc;
        int         exp_sc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 3'd3, 4'b1011, 1'b1, 3'd3, 4'b1100, 1, 0};
        vecs[1] = '{1'b1, 3'd5, 4'b1001, 1'b0, 3'd5, 4'b1001, 1, 0};
        vecs[2] = '{1'b0, 3'd2, 4'b1111, 1'b1, 3'd3, 4'b1000, 2, 0};
        vecs[3] = '{1'b1, 3'd7, 4'b1111, 1'b1, 3'd7, 4'b1111, 3, 1};
        vecs[4] = '{1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 3, 1};
        vecs[5] = '{1'b1, 3'd6, 4'b1111, 1'b1, 3'd7, 4'b1000, 4, 1};
        vecs[6] = '{1'b0, 3'd7, 4'b1110, 1'b1, 3'd7, 4'b1111, 5, 1};

        // Reset with a sample already offered.
        rst = 1'b1;
        clr = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 3'd3, 4'b1011, 1'b1);
        cyc();
        cyc();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_round_cnt", int'(round_cnt), 0);
        check("rst_sat_cnt", int'(sat_cnt), 0);
        check("rst_out_word", int'({out_S, out_E, out_F}), 0);
        rst = 1'b0;
        cyc();
        check("first_valid", int'(out_valid), 1);
        check("first_F", int'(out_F), 12);
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        cyc();
        check("first_drained", int'(out_valid), 0);

        // Vector table, back-to-back with out_ready high.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_round_cnt", int'(round_cnt), 0);
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].t);
            cyc();
            check("vec_valid", int'(out_valid), 1);
            check("vec_S", int'(out_S), int'(vecs[i].s));
            check("vec_E", int'(out_E), int'(vecs[i].exp_e));
            check("vec_F", int'(out_F), int'(vecs[i].exp_f));
            check("vec_round_cnt", int'(round_cnt), vecs[i].exp_rc);
            check("vec_sat_cnt", int'(sat_cnt), vecs[i].exp_sc);
        end
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        cyc();

        // Backpressure: A, B, C offered while out_ready is low.
        out_ready = 1'b0;
        set_in(1'b1, 1'b0, 3'd1, 4'd1, 1'b0);
        cyc();
        check("bp_A_valid", int'(out_valid), 1);
        check("bp_ready_after_A", int'(in_ready), 1);
        set_in(1'b1, 1'b0, 3'd2, 4'd2, 1'b0);
        cyc();
        check("bp_ready_after_B", int'(in_ready), 0);
        check("bp_hold_A", int'(out_F), 1);
        set_in(1'b1, 1'b0, 3'd3, 4'd3, 1'b0);
        cyc();
        check("bp_stall_C", int'(in_ready), 0);
        check("bp_still_A", int'(out_E), 1);
        out_ready = 1'b1;
        cyc();
        check("bp_out_B", int'(out_F), 2);
        cyc();
        check("bp_out_C", int'(out_F), 3);
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        cyc();
        check("bp_empty", int'(out_valid), 0);

        // Narrow-counter saturation and clr priority.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 3'd1, 4'd2, 1'b1);
            cyc();
            check("cnt2_round", int'(round_cnt2), (i < 3) ? i + 1 : 3);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("cnt2_clr", int'(round_cnt2), 0);
        check("cnt8_clr", int'(round_cnt), 0);
        cyc();

        // Asynchronous reset while OR and SK both hold data.
        out_ready = 1'b0;
        set_in(1'b1, 1'b0, 3'd4, 4'd5, 1'b0);
        cyc();
        set_in(1'b1, 1'b0, 3'd4, 4'd6, 1'b0);
        cyc();
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("ar_full_ready", int'(in_ready), 0);
        #1;
        rst = 1'b1;
        #1;
        check("ar_out_valid", int'(out_valid), 0);
        check("ar_in_ready", int'(in_ready), 1);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 3'd1, 4'b0000, 1'b1);
        cyc();
        check("ar_new_valid", int'(out_valid), 1);
        check("ar_new_F", int'(out_F), 1);
        check("ar_new_E", int'(out_E), 1);
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        cyc();
        check("ar_no_stale", int'(out_valid), 0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 4'($urandom),
                   1'($urandom));
            out_ready = $urandom_range(0, 9) < 6;
            clr = $urandom_range(0, 63) == 0;
            cyc();
        end
        set_in(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            cyc();
        end
        cyc();
        check("drain_empty", exp_q.size(), 0);
        check("drain_out_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Downstream stage of the normaliser. Consumes the sign, 3-bit exponent, 4-bit significand and fifth (rounding) bit produced for each converted sample.
- Rounds half-up on the fifth bit, handles significand carry-out and exponent saturation, and emits the final packed {S,E,F} 8-bit float.
- Registered valid/ready stage with a one-entry skid buffer, so the converter runs at one sample per clock under backpressure.
- Keeps saturating statistics counters for rounding and overflow events.

Parameters:
- CNT_W, 8, width of the round_cnt and sat_cnt statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of the statistics counters only.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  stage can accept a sample this cycle.
- S  input  1  sign bit, passed through.
- E  input  3  exponent from normaliser.
- M  input  4  significand from normaliser.
- T  input  1  fifth bit (round bit).
- out_valid  output  1  packed result valid.
- out_ready  input  1  downstream accepts the result.
- out_S  output  1  result sign.
- out_E  output  3  result exponent.
- out_F  output  4  result significand.
- round_cnt  output  CNT_W  accepted samples with T=1.
- sat_cnt  output  CNT_W  accepted samples that saturated.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_S=0, out_E=0, out_F=0, skid empty, in_ready=1, round_cnt=0, sat_cnt=0.
- Rounding is combinational on input fields and registered once:
  - T=0: F=M, Eo=E.
  - T=1, M<15: F=M+1, Eo=E.
  - T=1, M=15, E<7: F=4'b1000, Eo=E+1.
  - T=1, M=15, E=7: saturate, F=4'b1111, Eo=7, sat event.
- S is never altered. Arithmetic is 4/3-bit unsigned with no wrap; the only overflow path is the saturate case above.
- Handshake rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Input fields are sampled only on in_fire.
- Storage: one output register (OR) and one skid register (SK), each with a full flag.
- in_ready is a registered output equal to !SK.full.
- Per-edge update:
  - OR empty, or out_fire: OR loads SK if SK full (SK empties), else the rounded input if in_fire, else OR empties.
  - OR full, no out_fire, in_fire: rounded input goes to SK (SK fills).
  - SK full and in_fire cannot both hold, since in_ready=0 while SK is full.
- Latency: a sample accepted at edge N with OR free is visible on out_* with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 sample/cycle while out_ready=1.
- Ordering: strictly FIFO and no sample is ever dropped. out_* remains stable while out_valid=1 and out_ready=0.
- Counters:
  - On in_fire, round_cnt increments if T=1 and sat_cnt increments if the saturate case applies.
  - Both counters stick at all-ones.
  - clr=1 zeroes both counters at the edge; clr wins over a simultaneous increment.
  - clr does not affect the datapath.
- Reset mid-operation: any held OR/SK contents are discarded immediately. out_valid drops asynchronously and in_ready returns to 1.

Test Plan:
1. Reset with in_valid=1 held -> out_valid=0, in_ready=1, counters 0 during rst. After rst release, the first accepted sample appears one cycle later.
2. S=0,E=3,M=4'b1011,T=1 with out_ready=1 -> out_E=3, out_F=4'b1100, round_cnt=1. Then S=1,E=5,M=4'b1001,T=0 -> out_S=1, out_E=5, out_F=4'b1001, round_cnt unchanged.
3. E=2,M=4'b1111,T=1 -> out_E=3, out_F=4'b1000, sat_cnt=0. E=7,M=4'b1111,T=1 -> out_E=7, out_F=4'b1111, sat_cnt=1.
4. out_ready=0 with samples A,B,C offered back-to-back -> A,B accepted and in_ready=0 on the next cycle, so C stalls. out_* hold A. Raising out_ready gives A,B,C in order on consecutive cycles with none lost or duplicated.
5. CNT_W=2 with five T=1 samples -> round_cnt reads 1,2,3,3,3. clr pulsed together with a sixth T=1 sample -> round_cnt=0.
6. rst asserted asynchronously between clock edges while OR and SK are full -> out_valid=0 immediately and in_ready=1. After release, a new sample E=1,M=4'b0000,T=1 -> out_F=4'b0001 with no stale data emitted.
